// File: rtl/apb_core_master_if.sv
// apb_core_master_if
//   Bundles the core-side request/response signals and the APB master port
//   of one apb_core_master.
//   master modport : the bridge itself (drives core_rdata/ack/err/busy and M_P*).
//   slave modport  : the environment (core plus APB interconnect).
interface apb_core_master_if #(
    parameter int BUS_WIDTH = 16
);
    // core side
    logic                 core_req;
    logic                 core_we;
    logic [BUS_WIDTH-1:0] core_addr;
    logic [BUS_WIDTH-1:0] core_wdata;
    logic [BUS_WIDTH-1:0] core_rdata;
    logic                 core_ack;
    logic                 core_err;
    logic                 core_busy;
    // APB side
    logic [BUS_WIDTH-1:0] M_PADDR;
    logic                 M_PWRITE;
    logic                 M_PSELx;
    logic                 M_PENABLE;
    logic [BUS_WIDTH-1:0] M_PWDATA;
    logic [BUS_WIDTH-1:0] M_PRDATA;
    logic                 M_PREADY;

    modport master (
        input  core_req, core_we, core_addr, core_wdata, M_PRDATA, M_PREADY,
        output core_rdata, core_ack, core_err, core_busy,
               M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );

    modport slave (
        output core_req, core_we, core_addr, core_wdata, M_PRDATA, M_PREADY,
        input  core_rdata, core_ack, core_err, core_busy,
               M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );
endinterface

// File: rtl/apb_core_master.sv
// apb_core_master
//   Initiator end of a per-core APB bus. A one-cycle core request becomes an
//   APB SETUP->ACCESS transfer; read data and a completion pulse go back to
//   the core. Transfers stalled in ACCESS for TIMEOUT cycles are aborted with
//   core_err (TIMEOUT=0 disables the abort).
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : apb_core_master_if.master (core request/response + APB master port)
// Every output is a flop; next values are decoded from the next state.
module apb_core_master #(
    parameter int BUS_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               reset,
    apb_core_master_if.master  bus
);
    // counter must be able to hold TIMEOUT itself
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [BUS_WIDTH-1:0] paddr_q, paddr_nx;
    logic [BUS_WIDTH-1:0] pwdata_q, pwdata_nx;
    logic                 pwrite_q, pwrite_nx;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_nx;
    logic                 ack_q, ack_nx;
    logic                 err_q, err_nx;
    logic                 psel_q, psel_nx;
    logic                 pen_q, pen_nx;
    logic                 busy_q, busy_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            paddr_q  <= paddr_nx;
            pwdata_q <= pwdata_nx;
            pwrite_q <= pwrite_nx;
            rdata_q  <= rdata_nx;
            ack_q    <= ack_nx;
            err_q    <= err_nx;
            psel_q   <= psel_nx;
            pen_q    <= pen_nx;
            busy_q   <= busy_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        paddr_nx  = paddr_q;
        pwdata_nx = pwdata_q;
        pwrite_nx = pwrite_q;
        rdata_nx  = '0;
        ack_nx    = 1'b0;
        err_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                // requests in any other state are dropped, not queued
                if (bus.core_req) begin
                    state_nx  = SETUP;
                    paddr_nx  = bus.core_addr;
                    pwrite_nx = bus.core_we;
                    pwdata_nx = bus.core_wdata;
                    cnt_nx    = '0;
                end
            end
            SETUP: state_nx = ACCESS;
            ACCESS: begin
                // PREADY is checked first so it wins over a same-cycle timeout
                if (bus.M_PREADY) begin
                    state_nx = DONE;
                    ack_nx   = 1'b1;
                    rdata_nx = pwrite_q ? '0 : bus.M_PRDATA;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    state_nx = DONE;
                    ack_nx   = 1'b1;
                    err_nx   = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        psel_nx = (state_nx == SETUP) || (state_nx == ACCESS);
        pen_nx  = (state_nx == ACCESS);
        busy_nx = (state_nx != IDLE);
    end

    assign bus.core_rdata = rdata_q;
    assign bus.core_ack   = ack_q;
    assign bus.core_err   = err_q;
    assign bus.core_busy  = busy_q;
    assign bus.M_PADDR    = paddr_q;
    assign bus.M_PWRITE   = pwrite_q;
    assign bus.M_PSELx    = psel_q;
    assign bus.M_PENABLE  = pen_q;
    assign bus.M_PWDATA   = pwdata_q;
endmodule

// File: tb/tb_apb_core_master.sv
module tb_apb_core_master;
    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t e;

    apb_core_master_if #(.BUS_WIDTH(16)) bus();

    apb_core_master #(.BUS_WIDTH(16), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock; lands mid-cycle (negedge) where outputs are sampled and inputs driven
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // drive a request during cycle 0, return observing cycle 1
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wd;
        cyc = 0;
        tick();
        bus.core_req = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int exp_cyc);
        while (bus.core_ack !== 1'b1 && cyc < 40) tick();
        chk({tag, "_lat"}, cyc, exp_cyc);
        if (bus.core_ack === 1'b1) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_rdata"}, bus.core_rdata, e.rdata);
                chk({tag, "_err"}, bus.core_err, e.err);
            end else chk({tag, "_unexpected_ack"}, 1, 0);
            chk({tag, "_psel_done"}, bus.M_PSELx, 0);
            chk({tag, "_busy_done"}, bus.core_busy, 1);
        end
    endtask

    initial begin
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        bus.M_PRDATA = 16'hFFFF; bus.M_PREADY = 1;
        tick();
        // reset state
        chk("rst_psel", bus.M_PSELx, 0);
        chk("rst_pen", bus.M_PENABLE, 0);
        chk("rst_busy", bus.core_busy, 0);
        chk("rst_ack", bus.core_ack, 0);
        chk("rst_paddr", bus.M_PADDR, 0);
        reset = 0;
        tick(); tick();

        // 1: write, PREADY high; PRDATA garbage must not leak into rdata
        issue(1, 16'h00A0, 16'h0055);
        sb.push_back('{rdata: 16'h0, err: 1'b0});
        chk("t1_setup_psel", bus.M_PSELx, 1);
        chk("t1_setup_pen", bus.M_PENABLE, 0);
        chk("t1_paddr", bus.M_PADDR, 16'h00A0);
        chk("t1_pwrite", bus.M_PWRITE, 1);
        chk("t1_pwdata", bus.M_PWDATA, 16'h0055);
        chk("t1_busy", bus.core_busy, 1);
        tick();
        chk("t1_access_pen", bus.M_PENABLE, 1);
        wait_ack("t1", 3);
        tick();
        chk("t1_idle_busy", bus.core_busy, 0);
        chk("t1_idle_rdata", bus.core_rdata, 0);
        chk("t1_hold_paddr", bus.M_PADDR, 16'h00A0);

        // 2: read with 3 wait states
        bus.M_PREADY = 0; bus.M_PRDATA = 16'hBEEF;
        issue(0, 16'h0085, 16'h0000);
        sb.push_back('{rdata: 16'hBEEF, err: 1'b0});
        chk("t2_pwrite", bus.M_PWRITE, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_paddr", bus.M_PADDR, 16'h0085);
            chk("t2_pen", bus.M_PENABLE, 1);
        end
        bus.M_PREADY = 1;
        wait_ack("t2", 6);
        tick();

        // 3: timeout after 4 ACCESS cycles
        bus.M_PREADY = 0; bus.M_PRDATA = 16'h1234;
        issue(0, 16'h0033, 16'h0000);
        sb.push_back('{rdata: 16'h0, err: 1'b1});
        tick(); tick(); tick(); tick();
        chk("t3_pen_last", bus.M_PENABLE, 1);
        chk("t3_ack_early", bus.core_ack, 0);
        wait_ack("t3", 6);
        tick();
        chk("t3_err_clr", bus.core_err, 0);

        // 4: extra request during ACCESS is dropped
        issue(1, 16'h0010, 16'h0077);
        sb.push_back('{rdata: 16'h0, err: 1'b0});
        tick();
        bus.core_req = 1; bus.core_addr = 16'h0099; bus.core_wdata = 16'h00EE;
        tick();
        bus.core_req = 0;
        chk("t4_paddr", bus.M_PADDR, 16'h0010);
        chk("t4_pwdata", bus.M_PWDATA, 16'h0077);
        bus.M_PREADY = 1;
        wait_ack("t4", 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_no_second_psel", bus.M_PSELx, 0);
            chk("t4_no_second_ack", bus.core_ack, 0);
        end
        chk("t4_sb_empty", sb.size(), 0);

        // 5: reset mid-ACCESS
        bus.M_PREADY = 0;
        issue(0, 16'h0044, 16'h0000);
        tick();
        chk("t5_in_access", bus.M_PENABLE, 1);
        reset = 1;
        #1;
        chk("t5_psel", bus.M_PSELx, 0);
        chk("t5_pen", bus.M_PENABLE, 0);
        chk("t5_busy", bus.core_busy, 0);
        chk("t5_paddr", bus.M_PADDR, 0);
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_ack", bus.core_ack, 0);
        end
        bus.M_PREADY = 1; bus.M_PRDATA = 16'h5A5A;
        issue(0, 16'h0046, 16'h0000);
        sb.push_back('{rdata: 16'h5A5A, err: 1'b0});
        chk("t5_setup_paddr", bus.M_PADDR, 16'h0046);
        wait_ack("t5", 3);
        tick();

        // 6: back-to-back, second request in first IDLE cycle after DONE
        issue(1, 16'h0020, 16'h0011);
        sb.push_back('{rdata: 16'h0, err: 1'b0});
        wait_ack("t6a", 3);
        tick();
        chk("t6_idle_psel", bus.M_PSELx, 0);
        chk("t6_idle_busy", bus.core_busy, 0);
        issue(1, 16'h0022, 16'h0033);
        sb.push_back('{rdata: 16'h0, err: 1'b0});
        chk("t6_setup_psel", bus.M_PSELx, 1);
        chk("t6_setup_pen", bus.M_PENABLE, 0);
        chk("t6_paddr", bus.M_PADDR, 16'h0022);
        tick();
        chk("t6_access_psel", bus.M_PSELx, 1);
        wait_ack("t6b", 3);
        tick();
        chk("t6_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
